// File: rtl/ram_bank_if.sv
// Request/response bundle for ram_bank: write port, read port, clear request and status.
// The master drives requests; the slave (the RAM) returns busy and read data.
interface ram_bank_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 4
);
  logic                   clear;
  logic                   busy;
  logic                   write_enable;
  logic [A_WIDTH-1:0]     address_write;
  logic [D_WIDTH-1:0]     data_write;
  logic [D_WIDTH/8-1:0]   byte_enable;
  logic                   read_enable;
  logic [A_WIDTH-1:0]     address_read;
  logic [D_WIDTH-1:0]     data_read;
  logic                   read_valid;

  modport master (
    output clear, write_enable, address_write, data_write, byte_enable,
           read_enable, address_read,
    input  busy, data_read, read_valid
  );

  modport slave (
    input  clear, write_enable, address_write, data_write, byte_enable,
           read_enable, address_read,
    output busy, data_read, read_valid
  );
endinterface

// File: rtl/ram_bank.sv
// Single-clock 1R1W RAM with byte enables, 1- or 2-cycle read latency,
// optional read-during-write bypass and a clear sweep run after reset or on request.
module ram_bank #(
  parameter int               D_WIDTH   = 16,
  parameter int               A_WIDTH   = 4,
  parameter int               A_MAX     = 16,
  parameter int               RD_LAT    = 1,
  parameter int               BYPASS    = 1,
  parameter logic [D_WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_bank_if.slave bus
);

  localparam int NB = D_WIDTH / 8;
  localparam int IW = (A_MAX > 1) ? $clog2(A_MAX) : 1;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IW-1:0]      r_clr_addr;
  logic [IW-1:0]      w_clr_addr_next;

  logic [D_WIDTH-1:0] r_mem [A_MAX];

  logic               w_busy;
  logic               w_accept;
  logic               w_wr_in_range;
  logic               w_rd_in_range;
  logic               w_wr_go;
  logic               w_rd_go;
  logic [IW-1:0]      w_wr_idx;
  logic [IW-1:0]      w_rd_idx;
  logic [IW-1:0]      w_mem_idx;
  logic [D_WIDTH-1:0] w_mem_wdata;
  logic [NB-1:0]      w_byte_we;
  logic [D_WIDTH-1:0] w_mem_rword;
  logic [D_WIDTH-1:0] w_merged;
  logic               w_hit;
  logic [D_WIDTH-1:0] w_rd_word;

  logic               r_s1_valid;
  logic [D_WIDTH-1:0] r_s1_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_addr == IW'(A_MAX - 1)) begin
          w_state_next    = ST_READY;
          w_clr_addr_next = '0;
        end else begin
          w_clr_addr_next = r_clr_addr + IW'(1);
        end
      end
      ST_READY: begin
        if (bus.clear) begin
          w_state_next    = ST_CLEAR;
          w_clr_addr_next = '0;
        end
      end
      default: begin
        w_state_next    = ST_CLEAR;
        w_clr_addr_next = '0;
      end
    endcase
  end

  assign w_busy   = (r_state == ST_CLEAR);
  assign bus.busy = w_busy;

  // clear wins over any user access issued in the same cycle
  assign w_accept = (r_state == ST_READY) && !bus.clear;

  assign w_wr_in_range = ({1'b0, bus.address_write} < (A_WIDTH + 1)'(A_MAX));
  assign w_rd_in_range = ({1'b0, bus.address_read}  < (A_WIDTH + 1)'(A_MAX));
  assign w_wr_idx      = bus.address_write[IW-1:0];
  assign w_rd_idx      = bus.address_read[IW-1:0];
  assign w_wr_go       = w_accept && bus.write_enable && w_wr_in_range;
  assign w_rd_go       = w_accept && bus.read_enable;

  // ---------------------------------------------------------------- array write
  assign w_mem_idx   = w_busy ? r_clr_addr : w_wr_idx;
  assign w_mem_wdata = w_busy ? CLR_VALUE  : bus.data_write;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign w_byte_we[gi] = w_busy || (w_wr_go && bus.byte_enable[gi]);
      assign w_merged[8*gi +: 8] = bus.byte_enable[gi] ? bus.data_write[8*gi +: 8]
                                                       : w_mem_rword[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_byte_we[b]) begin
        r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read path
  assign w_mem_rword = r_mem[w_rd_idx];
  assign w_hit       = (BYPASS != 0) && w_wr_go && (bus.address_write == bus.address_read);

  always_comb begin
    w_rd_word = w_mem_rword;
    if (!w_rd_in_range) begin
      w_rd_word = '0;
    end else if (w_hit) begin
      w_rd_word = w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_go;
      if (w_rd_go) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  // The second stage is not gated by busy so reads already in flight finish.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic               r_s2_valid;
      logic [D_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign bus.read_valid = r_s2_valid;
      assign bus.data_read  = r_s2_data;
    end else begin : g_lat1
      assign bus.read_valid = r_s1_valid;
      assign bus.data_read  = r_s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: two instances share stimulus, one with RD_LAT=1/BYPASS=1/CLR=0,
// the other with RD_LAT=2/BYPASS=0/CLR=0x5A5A, both with A_MAX=20 on a 5-bit address.
module tb_ram_bank;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int AM = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          t_clear = 1'b0;
  logic          t_we    = 1'b0;
  logic          t_re    = 1'b0;
  logic [AW-1:0] t_aw    = '0;
  logic [AW-1:0] t_ar    = '0;
  logic [DW-1:0] t_dw    = '0;
  logic [1:0]    t_be    = '0;

  ram_bank_if #(.D_WIDTH(DW), .A_WIDTH(AW)) if_a ();
  ram_bank_if #(.D_WIDTH(DW), .A_WIDTH(AW)) if_b ();

  assign if_a.clear = t_clear;         assign if_b.clear = t_clear;
  assign if_a.write_enable = t_we;     assign if_b.write_enable = t_we;
  assign if_a.address_write = t_aw;    assign if_b.address_write = t_aw;
  assign if_a.data_write = t_dw;       assign if_b.data_write = t_dw;
  assign if_a.byte_enable = t_be;      assign if_b.byte_enable = t_be;
  assign if_a.read_enable = t_re;      assign if_b.read_enable = t_re;
  assign if_a.address_read = t_ar;     assign if_b.address_read = t_ar;

  ram_bank #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .RD_LAT(1), .BYPASS(1),
             .CLR_VALUE(16'h0000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  ram_bank #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .RD_LAT(2), .BYPASS(0),
             .CLR_VALUE(16'h5A5A)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    t_clear = 1'b0; t_we = 1'b0; t_re = 1'b0; t_be = '0;
  endtask

  task automatic reset_state(input string tag, input logic [DW-1:0] prev_b);
    check({tag, "_busy_a"}, if_a.busy, 1);
    check({tag, "_busy_b"}, if_b.busy, 1);
    check({tag, "_valid_a"}, if_a.read_valid, 0);
    check({tag, "_valid_b"}, if_b.read_valid, 0);
    check({tag, "_data_a"}, if_a.data_read, 0);
    check({tag, "_data_b"}, if_b.data_read, 0);
    $display("reset %s: busy=%0b/%0b prev_b=0x%0h", tag, if_a.busy, if_b.busy, prev_b);
  endtask

  // Counts busy edges for each instance; optionally keeps a read request up the whole time.
  task automatic wait_ready(input string tag, input bit hold_rd);
    int ca = 0;
    int cb = 0;
    int n = 0;
    int spurious = 0;
    t_re = hold_rd;
    t_ar = 5'd4;
    while ((if_a.busy || if_b.busy) && n < 200) begin
      if (if_a.busy) ca++;
      if (if_b.busy) cb++;
      step();
      n++;
      if (if_a.read_valid || if_b.read_valid) spurious++;
    end
    t_re = 1'b0;
    check({tag, "_busy_cycles_a"}, ca, AM);
    check({tag, "_busy_cycles_b"}, cb, AM);
    check({tag, "_dropped_reads"}, spurious, 0);
    $display("sweep %s: busy_a=%0d busy_b=%0d spurious=%0d", tag, ca, cb, spurious);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] be);
    t_we = 1'b1; t_aw = addr; t_dw = data; t_be = be;
    step();
    t_we = 1'b0; t_be = '0;
    $display("write addr=%0d data=0x%0h be=%b", addr, data, be);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] addr,
                    input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    t_re = 1'b1; t_ar = addr;
    step();
    t_re = 1'b0; t_we = 1'b0; t_be = '0;
    check({tag, "_valid_a"}, if_a.read_valid, 1);
    check({tag, "_data_a"}, if_a.data_read, ea);
    check({tag, "_early_b"}, if_b.read_valid, 0);
    step();
    check({tag, "_valid_b"}, if_b.read_valid, 1);
    check({tag, "_data_b"}, if_b.data_read, eb);
    check({tag, "_pulse_a"}, if_a.read_valid, 0);
    check({tag, "_hold_a"}, if_a.data_read, ea);
    $display("read %s addr=%0d a=0x%0h b=0x%0h", tag, addr, if_a.data_read, if_b.data_read);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (3) step();
    reset_state("por", 16'h0);
    rst_n = 1'b1;
    wait_ready("por", 1'b0);

    rd("clr5", 5'd5, 16'h0000, 16'h5A5A);
    rd("oor27", 5'd27, 16'h0000, 16'h0000);

    wr(5'd11, 16'h00C5, 2'b01);
    rd("byte_lo", 5'd11, 16'h00C5, 16'h5AC5);

    wr(5'd7, 16'hBEEF, 2'b11);
    wr(5'd7, 16'h1234, 2'b10);
    rd("merge", 5'd7, 16'h12EF, 16'h12EF);
    wr(5'd7, 16'hFFFF, 2'b00);
    rd("be_zero", 5'd7, 16'h12EF, 16'h12EF);

    t_we = 1'b1; t_aw = 5'd3; t_dw = 16'hAA55; t_be = 2'b11;
    rd("rdw", 5'd3, 16'hAA55, 16'h5A5A);
    rd("after_rdw", 5'd3, 16'hAA55, 16'hAA55);

    wr(5'd25, 16'hFFFF, 2'b11);
    rd("oor25", 5'd25, 16'h0000, 16'h0000);
    rd("last19", 5'd19, 16'h0000, 16'h5A5A);
    rd("first0", 5'd0, 16'h0000, 16'h5A5A);

    // back-to-back reads, one result per cycle
    t_re = 1'b1; t_ar = 5'd7;
    step();
    check("b2b_1_valid_a", if_a.read_valid, 1);
    check("b2b_1_data_a", if_a.data_read, 16'h12EF);
    check("b2b_1_valid_b", if_b.read_valid, 0);
    t_ar = 5'd3;
    step();
    t_re = 1'b0;
    check("b2b_2_valid_a", if_a.read_valid, 1);
    check("b2b_2_data_a", if_a.data_read, 16'hAA55);
    check("b2b_2_valid_b", if_b.read_valid, 1);
    check("b2b_2_data_b", if_b.data_read, 16'h12EF);
    step();
    check("b2b_3_valid_a", if_a.read_valid, 0);
    check("b2b_3_valid_b", if_b.read_valid, 1);
    check("b2b_3_data_b", if_b.data_read, 16'hAA55);
    $display("read b2b a=0x%0h b=0x%0h", if_a.data_read, if_b.data_read);

    // read in flight, then clear together with a write to address 4
    t_re = 1'b1; t_ar = 5'd7;
    step();
    t_re = 1'b0;
    t_clear = 1'b1; t_we = 1'b1; t_aw = 5'd4; t_dw = 16'h7777; t_be = 2'b11;
    step();
    idle();
    check("clr_busy_a", if_a.busy, 1);
    check("clr_busy_b", if_b.busy, 1);
    check("inflight_valid_b", if_b.read_valid, 1);
    check("inflight_data_b", if_b.data_read, 16'h12EF);
    check("clr_no_read_a", if_a.read_valid, 0);
    $display("clear issued: busy=%0b/%0b inflight_b=0x%0h", if_a.busy, if_b.busy, if_b.data_read);
    wait_ready("clear", 1'b1);
    rd("clr4", 5'd4, 16'h0000, 16'h5A5A);
    rd("clr7", 5'd7, 16'h0000, 16'h5A5A);
    rd("clr3", 5'd3, 16'h0000, 16'h5A5A);

    // reset while a read is pending
    t_re = 1'b1; t_ar = 5'd11;
    wr(5'd11, 16'h3C3C, 2'b11);
    t_re = 1'b1; t_ar = 5'd11;
    step();
    t_re = 1'b0;
    check("prerst_data_a", if_a.data_read, 16'h3C3C);
    rst_n = 1'b0;
    #1;
    reset_state("rst_read", if_b.data_read);
    step();
    check("rst_read_discard_b", if_b.read_valid, 0);
    rst_n = 1'b1;
    wait_ready("rst_read", 1'b0);

    // reset in the middle of a clear sweep
    wr(5'd2, 16'h1111, 2'b11);
    t_clear = 1'b1;
    step();
    t_clear = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    reset_state("rst_sweep", if_b.data_read);
    step();
    rst_n = 1'b1;
    wait_ready("rst_sweep", 1'b0);
    rd("after_rst", 5'd2, 16'h0000, 16'h5A5A);
    rd("after_rst11", 5'd11, 16'h0000, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised single-clock 1R1W RAM that supersedes the dual-clock RAM with its single write enable. It adds per-byte write enables, a selectable read latency of 1 or 2 cycles, and a read-during-write bypass. A hardware clear sequencer zeroes the array after reset and on request. It sits in the datapath as generic scratch/buffer storage behind FIFOs and register files.

## Interface
- D_WIDTH, 16, data width in bits; must be a multiple of 8.
- A_WIDTH, 4, address width in bits.
- A_MAX, 16, number of words; 1 ≤ A_MAX ≤ 2^A_WIDTH.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, behaviour on same-address read/write: 1 = return new data, 0 = return old data.
- CLR_VALUE, 0, word value written by the clear sweep.
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clear  input  1  request to re-run the clear sweep; sampled only in READY.
- busy  output  1  high while the sweep runs; reads and writes are ignored while busy.
- write_enable  input  1  write request.
- address_write  input  A_WIDTH  write address.
- data_write  input  D_WIDTH  write data.
- byte_enable  input  D_WIDTH/8  per-byte write mask; bit i enables data bits [8i+7:8i].
- read_enable  input  1  read request.
- address_read  input  A_WIDTH  read address.
- data_read  output  D_WIDTH  read data; holds its value between reads.
- read_valid  output  1  one-cycle pulse, aligned with each new data_read.

## Operation
- The FSM has two states, CLEAR and READY. Reset forces CLEAR with sweep counter clr_addr = 0.
- CLEAR:
  - Each cycle, write CLR_VALUE to memory[clr_addr] and increment clr_addr.
  - After the write to A_MAX-1, go to READY and reset clr_addr to 0.
  - clear is ignored in this state. User reads and writes are dropped; no read_valid is generated for them.
- READY:
  - Writes: write_enable=1 updates only the enabled bytes of memory[address_write]. If byte_enable = 0, memory is unchanged.
  - Reads: read_enable=1 is accepted and produces exactly one read_valid pulse RD_LAT cycles later.
  - clear=1 goes to CLEAR. clear has priority: a write or read in the same cycle is dropped.
- Out-of-range addresses (≥ A_MAX):
  - Writes are dropped.
  - Reads are accepted and return 0 with read_valid=1.
- Same-address read and write in the same cycle:
  - BYPASS=1: returns the merged word (enabled bytes from data_write, the rest from memory).
  - BYPASS=0: returns the pre-write word.
- Reads already in flight when busy rises (RD_LAT=2) complete normally.
- The memory array itself has no reset. Its contents are defined only after the first sweep finishes.

## Timing
- Reset values while rst_n=0: busy=1, data_read=0, read_valid=0, state=CLEAR, clr_addr=0.
- Sweep timing:
  - The first sweep write happens on the first posedge after rst_n rises.
  - busy stays high for exactly A_MAX cycles after reset release, then falls after the edge that writes A_MAX-1.
- clear sampled at edge N: busy=1 from edge N. The sweep writes at edges N+1..N+A_MAX, and busy falls after edge N+A_MAX.
- busy is registered and never combinational from clear.
- Read accepted at edge N:
  - RD_LAT=1: data_read and read_valid update at edge N.
  - RD_LAT=2: they update at edge N+1.
- Back-to-back reads every cycle give one result per cycle (full throughput, no bubbles).
- A write at edge N is visible to a read accepted at edge N+1 in all modes. It is visible at edge N only when BYPASS=1.
- Reset asserted mid-sweep or mid-read: all pending reads are discarded, read_valid=0 immediately, and the sweep restarts from 0 after release.

## Test plan
- Reset release, D_WIDTH=8, A_WIDTH=5, A_MAX=32 -> busy high for exactly 32 cycles; a read of 0x1B right after busy falls returns 0x00 with read_valid 1 cycle later.
- Write 0xC5 to 0x1B with byte_enable=1, then read 0x1B -> data_read=0xC5, with read_valid after 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2).
- D_WIDTH=16: write 0xBEEF, then write 0x1234 with byte_enable=2'b10 to the same address -> read returns 0x12EF.
- Same-cycle write 0xAA55 (full mask) and read of address 3, holding 0x0000 -> BYPASS=1 returns 0xAA55, BYPASS=0 returns 0x0000; a read in the next cycle returns 0xAA55 in both modes.
- A_MAX=20, A_WIDTH=5: write to 25, then read 25 -> data_read=0, read_valid=1; memory[0..19] unchanged.
- clear asserted together with write_enable to address 4 -> write dropped, busy high for A_MAX cycles, all words read back as CLR_VALUE; rst_n pulsed mid-sweep -> busy stays high and the sweep restarts, lasting A_MAX cycles after release.
